// File: rtl/video_timing_pkg.sv
// Shared video timing constants and types: 720p60 defaults, a 480p set for
// other video blocks, the RGB width and the sync bundle layout.
package video_timing_pkg;

  localparam int RGB_W = 24;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int H_ACTIVE_480P = 640;
  localparam int H_FP_480P     = 16;
  localparam int H_SYNC_480P   = 96;
  localparam int H_BP_480P     = 48;
  localparam int V_ACTIVE_480P = 480;
  localparam int V_FP_480P     = 10;
  localparam int V_SYNC_480P   = 2;
  localparam int V_BP_480P     = 33;

  typedef struct packed {
    logic frame_start;
    logic de;
    logic vsync;
    logic hsync;
  } sync_t;

  function automatic int line_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_scan_timing_if.sv
// Pixel-generator link: coordinates and dimensions out, RGB back.
interface video_scan_timing_if
  import video_timing_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 11
);
  logic [X_BITS-1:0] pixX;
  logic [Y_BITS-1:0] pixY;
  logic [X_BITS-1:0] screenWidth;
  logic [Y_BITS-1:0] screenHeight;
  logic [X_BITS-1:0] frameWidth;
  logic [Y_BITS-1:0] frameHeight;
  logic [RGB_W-1:0]  I_rgb;

  modport master (
    output pixX, pixY, screenWidth, screenHeight, frameWidth, frameHeight,
    input  I_rgb
  );

  modport slave (
    input  pixX, pixY, screenWidth, screenHeight, frameWidth, frameHeight,
    output I_rgb
  );
endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a chosen idle word.
module sync_delay_line #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_scan_timing.sv
// Raster counter and sync generator; aligns sync/de with the pixel generator's
// returned RGB and presents one coherent pixel stream to the encoder.
module video_scan_timing
  import video_timing_pkg::*;
#(
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 11,
  parameter int H_ACTIVE    = H_ACTIVE_720P,
  parameter int H_FP        = H_FP_720P,
  parameter int H_SYNC      = H_SYNC_720P,
  parameter int H_BP        = H_BP_720P,
  parameter int V_ACTIVE    = V_ACTIVE_720P,
  parameter int V_FP        = V_FP_720P,
  parameter int V_SYNC      = V_SYNC_720P,
  parameter int V_BP        = V_BP_720P,
  parameter bit SYNC_POL    = 1'b1,
  parameter int GEN_LATENCY = 1
) (
  input  logic              I_clk_pixel,
  input  logic              I_reset_n,
  video_scan_timing_if.master pg,
  output logic [RGB_W-1:0]  O_rgb,
  output logic              O_hsync,
  output logic              O_vsync,
  output logic              O_de,
  output logic              O_frame_start
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DEPTH   = GEN_LATENCY + 1;
  localparam sync_t SYNC_IDLE = '{frame_start: 1'b0, de: 1'b0,
                                  vsync: ~SYNC_POL, hsync: ~SYNC_POL};

  if (GEN_LATENCY < 1 || GEN_LATENCY > 4) begin : g_bad_latency
    $error("video_scan_timing: GEN_LATENCY must be 1..4");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("video_scan_timing: timing parameters must be non-zero");
  end
  if (H_TOTAL > (1 << X_BITS) || V_TOTAL > (1 << Y_BITS)) begin : g_bad_width
    $error("video_scan_timing: counter widths too small for frame size");
  end

  logic [X_BITS-1:0] pix_x_p0;
  logic [Y_BITS-1:0] pix_y_p0;
  sync_t             raw_p0;
  sync_t             sync_pd;
  logic [RGB_W-1:0]  rgb_p1;
  logic              hs_active;
  logic              vs_active;

  // Stage p0: raster counters, the only state the coordinates depend on
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      pix_x_p0 <= '0;
      pix_y_p0 <= '0;
    end else if (pix_x_p0 == X_BITS'(H_TOTAL - 1)) begin
      pix_x_p0 <= '0;
      pix_y_p0 <= (pix_y_p0 == Y_BITS'(V_TOTAL - 1)) ? '0 : pix_y_p0 + 1'b1;
    end else begin
      pix_x_p0 <= pix_x_p0 + 1'b1;
    end
  end

  always_comb begin
    hs_active = (pix_x_p0 >= X_BITS'(H_ACTIVE + H_FP)) &&
                (pix_x_p0 <  X_BITS'(H_ACTIVE + H_FP + H_SYNC));
    vs_active = (pix_y_p0 >= Y_BITS'(V_ACTIVE + V_FP)) &&
                (pix_y_p0 <  Y_BITS'(V_ACTIVE + V_FP + V_SYNC));
    raw_p0             = SYNC_IDLE;
    raw_p0.de          = (pix_x_p0 < X_BITS'(H_ACTIVE)) && (pix_y_p0 < Y_BITS'(V_ACTIVE));
    raw_p0.hsync       = hs_active ~^ SYNC_POL;
    raw_p0.vsync       = vs_active ~^ SYNC_POL;
    raw_p0.frame_start = (pix_x_p0 == '0) && (pix_y_p0 == '0);
  end

  assign pg.pixX         = pix_x_p0;
  assign pg.pixY         = pix_y_p0;
  assign pg.screenWidth  = X_BITS'(H_ACTIVE);
  assign pg.screenHeight = Y_BITS'(V_ACTIVE);
  assign pg.frameWidth   = X_BITS'(H_TOTAL);
  assign pg.frameHeight  = Y_BITS'(V_TOTAL);

  // Stages p1..pD: sync bundle delayed to meet the registered generator output
  sync_delay_line #(
    .WIDTH     ($bits(sync_t)),
    .DEPTH     (DEPTH),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (I_clk_pixel),
    .rst_n (I_reset_n),
    .d     (raw_p0),
    .q     (sync_pd)
  );

  // Final stage: RGB capture; blanking forced black by the delayed de
  always_ff @(posedge I_clk_pixel) begin
    rgb_p1 <= pg.I_rgb;
  end

  assign O_rgb         = sync_pd.de ? rgb_p1 : '0;
  assign O_hsync       = sync_pd.hsync;
  assign O_vsync       = sync_pd.vsync;
  assign O_de          = sync_pd.de;
  assign O_frame_start = sync_pd.frame_start;

endmodule

// File: tb/tb_video_scan_timing.sv
// Bench for video_scan_timing: two small-raster instances (positive sync with
// latency 1, negative sync with latency 3) checked against a raster model.
module tb_video_scan_timing;
  localparam int XB = 12, YB = 11;
  localparam int HA = 16, HF = 3, HS = 4, HB = 5, HT = HA + HF + HS + HB;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int DA = 2, DB = 4;
  localparam int VW = XB + YB + 24 + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  video_scan_timing_if #(.X_BITS(XB), .Y_BITS(YB)) ifa ();
  video_scan_timing_if #(.X_BITS(XB), .Y_BITS(YB)) ifb ();

  logic [23:0] rgb_a, rgb_b;
  logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;

  video_scan_timing #(
    .X_BITS(XB), .Y_BITS(YB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1), .GEN_LATENCY(1)
  ) dut_a (
    .I_clk_pixel(clk), .I_reset_n(rst_n), .pg(ifa), .O_rgb(rgb_a),
    .O_hsync(hs_a), .O_vsync(vs_a), .O_de(de_a), .O_frame_start(fs_a)
  );

  video_scan_timing #(
    .X_BITS(XB), .Y_BITS(YB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .GEN_LATENCY(3)
  ) dut_b (
    .I_clk_pixel(clk), .I_reset_n(rst_n), .pg(ifb), .O_rgb(rgb_b),
    .O_hsync(hs_b), .O_vsync(vs_b), .O_de(de_b), .O_frame_start(fs_b)
  );

  logic [7:0] salt [HT][VT];
  int vectors = 0;
  int errors  = 0;
  int m = 0;

  function automatic logic [23:0] pat(logic [XB-1:0] x, logic [YB-1:0] y);
    if (x < HT && y < VT) return {x[7:0], y[7:0], salt[x][y]};
    return 24'd0;
  endfunction

  // Pixel-generator models with latency 1 and 3
  logic [23:0] ga0, gb0, gb1, gb2;
  always @(posedge clk) begin
    ga0 <= pat(ifa.pixX, ifa.pixY);
    gb0 <= pat(ifb.pixX, ifb.pixY);
    gb1 <= gb0;
    gb2 <= gb1;
  end
  assign ifa.I_rgb = ga0;
  assign ifb.I_rgb = gb2;

  // Expected outputs after m clocks since reset release; outputs show the
  // pixel counted d clocks earlier
  function automatic logic [VW-1:0] expect_vec(int mm, bit pol, int d, bit in_rst);
    logic [XB-1:0] cx;
    logic [YB-1:0] cy;
    logic [23:0] rgb;
    logic hs, vs, de, fs;
    int k, x, y;
    cx = '0; cy = '0; rgb = '0; hs = ~pol; vs = ~pol; de = 1'b0; fs = 1'b0;
    if (!in_rst) begin
      cx = XB'(mm % HT);
      cy = YB'((mm / HT) % VT);
      k = mm - d;
      if (k >= 0) begin
        x  = k % HT;
        y  = (k / HT) % VT;
        de = (x < HA) && (y < VA);
        hs = ((x >= HA + HF) && (x < HA + HF + HS)) ? pol : ~pol;
        vs = ((y >= VA + VF) && (y < VA + VF + VS)) ? pol : ~pol;
        fs = (x == 0) && (y == 0);
        rgb = de ? pat(XB'(x), YB'(y)) : 24'd0;
      end
    end
    return {cx, cy, rgb, hs, vs, de, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) m++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [VW-1:0] ea, eb;
    rst_n = 1'b0;
    repeat (3) tick();
    ea = expect_vec(0, 1'b1, DA, 1'b1);
    eb = expect_vec(0, 1'b0, DB, 1'b1);
    vectors++;
    if ({ifa.pixX, ifa.pixY, rgb_a, hs_a, vs_a, de_a, fs_a} !== ea) begin
      errors++;
      $display("FAIL reset_a got %h expected %h", {ifa.pixX, ifa.pixY, rgb_a, hs_a, vs_a, de_a, fs_a}, ea);
    end
    vectors++;
    if ({ifb.pixX, ifb.pixY, rgb_b, hs_b, vs_b, de_b, fs_b} !== eb) begin
      errors++;
      $display("FAIL reset_b got %h expected %h", {ifb.pixX, ifb.pixY, rgb_b, hs_b, vs_b, de_b, fs_b}, eb);
    end
    vectors++;
    if ({ifa.screenWidth, ifa.screenHeight, ifa.frameWidth, ifa.frameHeight} !==
        {XB'(HA), YB'(VA), XB'(HT), YB'(VT)}) begin
      errors++;
      $display("FAIL dims got %0d %0d %0d %0d expected %0d %0d %0d %0d", ifa.screenWidth,
               ifa.screenHeight, ifa.frameWidth, ifa.frameHeight, HA, VA, HT, VT);
    end
  endtask

  task automatic test_raster();
    logic [VW-1:0] ea, eb;
    int de_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0, hsb_low = 0, fsb_cnt = 0;
    rst_n = 1'b1;
    m = 0;
    for (int c = 0; c < 2 * FRAME + DB + 2; c++) begin
      ea = expect_vec(m, 1'b1, DA, 1'b0);
      eb = expect_vec(m, 1'b0, DB, 1'b0);
      vectors++;
      if ({ifa.pixX, ifa.pixY, rgb_a, hs_a, vs_a, de_a, fs_a} !== ea) begin
        errors++;
        $display("FAIL raster_a m=%0d got %h expected %h", m, {ifa.pixX, ifa.pixY, rgb_a, hs_a, vs_a, de_a, fs_a}, ea);
      end
      vectors++;
      if ({ifb.pixX, ifb.pixY, rgb_b, hs_b, vs_b, de_b, fs_b} !== eb) begin
        errors++;
        $display("FAIL raster_b m=%0d got %h expected %h", m, {ifb.pixX, ifb.pixY, rgb_b, hs_b, vs_b, de_b, fs_b}, eb);
      end
      if (m == DA + 3 * HT + 5) begin
        vectors++;
        if (rgb_a[23:8] !== 16'h0503) begin
          errors++;
          $display("FAIL pixel_5_3 got %h expected 0503xx", rgb_a);
        end
      end
      if (m >= DA && m < DA + 2 * FRAME) begin
        de_cnt += int'(de_a); fs_cnt += int'(fs_a);
        hs_cnt += int'(hs_a); vs_cnt += int'(vs_a);
      end
      if (m >= DB && m < DB + 2 * FRAME) begin
        hsb_low += int'(!hs_b); fsb_cnt += int'(fs_b);
      end
      tick();
    end
    vectors++;
    if (de_cnt !== 2 * HA * VA) begin
      errors++; $display("FAIL de_count got %0d expected %0d", de_cnt, 2 * HA * VA);
    end
    vectors++;
    if (fs_cnt !== 2 || fsb_cnt !== 2) begin
      errors++; $display("FAIL frame_start_count got %0d/%0d expected 2/2", fs_cnt, fsb_cnt);
    end
    vectors++;
    if (hs_cnt !== 2 * VT * HS || hsb_low !== 2 * VT * HS) begin
      errors++; $display("FAIL hsync_count got %0d/%0d expected %0d", hs_cnt, hsb_low, 2 * VT * HS);
    end
    vectors++;
    if (vs_cnt !== 2 * VS * HT) begin
      errors++; $display("FAIL vsync_count got %0d expected %0d", vs_cnt, 2 * VS * HT);
    end
  endtask

  // Run n checked cycles, assert reset mid-cycle (checked at once), hold it
  // for hold clocks, then release
  task automatic run_and_reset(int n, int hold, string tag);
    logic [VW-1:0] ea, eb;
    for (int c = 0; c < n + hold + 1; c++) begin
      if (c == n) begin
        #2 rst_n = 1'b0;
        #1;
      end
      ea = expect_vec(m, 1'b1, DA, !rst_n);
      eb = expect_vec(m, 1'b0, DB, !rst_n);
      vectors++;
      if ({ifa.pixX, ifa.pixY, rgb_a, hs_a, vs_a, de_a, fs_a} !== ea) begin
        errors++;
        $display("FAIL %s_a c=%0d got %h expected %h", tag, c, {ifa.pixX, ifa.pixY, rgb_a, hs_a, vs_a, de_a, fs_a}, ea);
      end
      vectors++;
      if ({ifb.pixX, ifb.pixY, rgb_b, hs_b, vs_b, de_b, fs_b} !== eb) begin
        errors++;
        $display("FAIL %s_b c=%0d got %h expected %h", tag, c, {ifb.pixX, ifb.pixY, rgb_b, hs_b, vs_b, de_b, fs_b}, eb);
      end
      if (c < n + hold) tick();
    end
    @(negedge clk);
    rst_n = 1'b1;
    m = 0;
  endtask

  task automatic test_mid_reset();
    run_and_reset(int'($urandom_range(100, 300)), 3, "mid_reset");
    run_and_reset(FRAME + DB + 3, 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_and_reset(int'($urandom_range(1, 40)), int'($urandom_range(1, 3)), "b2b");
    run_and_reset(DB + 4, 1, "b2b_final");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int x = 0; x < HT; x++)
      for (int y = 0; y < VT; y++)
        salt[x][y] = 8'($urandom);
    @(negedge clk);
    test_reset();
    test_raster();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/video_scan_timing.md
Name: video_scan_timing

Overview:
- Drives the pixel-coordinate side of the pixel-generator interface: counts the raster, presents pixX/pixY plus the screen/frame dimensions to the pixel generator, and registers the RGB value it returns.
- Generates hsync/vsync/de delayed to line up with the returned RGB, then hands a complete aligned pixel stream to the TMDS/HDMI encoder.
- Sits between the pixel clock domain root and the encoder. One instance per video output.

Parameters:
X_BITS, 12, width of pixX/screenWidth/frameWidth
Y_BITS, 11, width of pixY/screenHeight/frameHeight
H_ACTIVE, 1280, visible pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, visible lines
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
GEN_LATENCY, 1, pixel-generator latency in clocks from pixX/pixY to rgb; legal range 1..4

Ports:
I_clk_pixel  in  1  pixel clock
I_reset_n  in  1  asynchronous active-low reset
pixX  out  X_BITS  current horizontal count, 0..H_TOTAL-1
pixY  out  Y_BITS  current vertical count, 0..V_TOTAL-1
screenWidth  out  X_BITS  constant H_ACTIVE
screenHeight  out  Y_BITS  constant V_ACTIVE
frameWidth  out  X_BITS  constant H_TOTAL
frameHeight  out  Y_BITS  constant V_TOTAL
I_rgb  in  24  pixel from generator, {R,G,B}, valid GEN_LATENCY clocks after its coordinates
O_rgb  out  24  aligned pixel to encoder
O_hsync  out  1  aligned hsync
O_vsync  out  1  aligned vsync
O_de  out  1  aligned data enable
O_frame_start  out  1  one-clock pulse coincident with pixel (0,0) on O_de

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750). Both are derived localparams.
- Counters: pixX increments every clock. When pixX==H_TOTAL-1, pixX becomes 0 and pixY increments. When pixY==V_TOTAL-1 also holds at that point, pixY becomes 0. There is no other wrap path, and counters never exceed TOTAL-1.
- Active region is at the top-left: raw de = (pixX<H_ACTIVE)&&(pixY<V_ACTIVE).
- Raw hsync is active for H_ACTIVE+H_FP <= pixX < H_ACTIVE+H_FP+H_SYNC.
- Raw vsync is active for V_ACTIVE+V_FP <= pixY < V_ACTIVE+V_FP+V_SYNC. It is evaluated on pixY only, so its edges fall at pixX==0.
- Raw frame_start = (pixX==0)&&(pixY==0).
- Sync polarity: output level = active XNOR SYNC_POL, i.e. inactive level = ~SYNC_POL.
- Alignment:
  - I_rgb is registered into O_rgb, so total latency is D = GEN_LATENCY+1 clocks.
  - Raw de/hsync/vsync/frame_start pass through a D-stage register delay, so all outputs for coordinate (x,y) appear in the same clock.
  - O_rgb = delayed_de ? registered I_rgb : 24'd0. Blanking is always black.
- Reset (asynchronous assert, synchronous release):
  - pixX=0, pixY=0, O_rgb=0, O_de=0, O_frame_start=0.
  - O_hsync and O_vsync are held at their inactive level; every delay stage resets to these values.
  - After release, the first O_de=1 (pixel 0,0) occurs D clocks after the first counted cycle, and O_frame_start pulses with it.
- Reset mid-frame aborts the raster immediately and restarts at (0,0). No partial-line recovery.
- Dimension outputs are constants and unaffected by reset.
- Elaboration fails if GEN_LATENCY is outside 1..4 or any timing parameter is 0.

Decomposition:
- Package video_timing_pkg holds:
  - 720p60 default constants (H_ACTIVE…V_BP)
  - the RGB_W=24 constant
  - a 480p alternative constant set for reuse by other video blocks
- Sub-module sync_delay_line (parameters WIDTH, DEPTH, RESET_VAL): async-reset shift register used for the {frame_start, de, vsync, hsync} bundle.

Test Plan:
- Reset, then release; sample 1650×750 cycles -> pixX wraps 1649->0 with pixY +1, and pixY wraps 749->0 exactly once per 1,237,500 clocks.
- Generator model returns rgb={pixX[7:0],pixY[7:0],8'h00} with GEN_LATENCY=1 -> O_de high exactly 1280×720 clocks per frame. Each O_rgb equals the pattern of the coordinate whose de produced it, first pixel 24'h000000 and pixel (5,3) 24'h050300. O_rgb=0 whenever O_de=0.
- Count O_hsync with SYNC_POL=1 -> high for 40 clocks, rising 1390+2 clocks after pixX==0 of the line. O_vsync high for 5 lines starting at line 725, edge aligned with O_hsync's line boundary delay.
- Set SYNC_POL=0 and GEN_LATENCY=3 -> syncs inverted (idle high). O_de/O_frame_start appear 4 clocks after pixX==0,pixY==0. The rgb pattern stays aligned.
- Assert I_reset_n low at pixX=600,pixY=400 for 3 clocks -> outputs go to reset values asynchronously in the same cycle. After release, counting restarts at (0,0), and O_frame_start fires D clocks later.
- Run two full frames -> exactly one O_frame_start per frame, each coincident with O_de rising on line 0.
